// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared bus width, arbiter state encoding, grant owners and abort read data.
package cpu_bus_pkg;
    localparam int BUS_W = 32;
    localparam logic [BUS_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} arb_state_e;
    typedef enum logic {GRANT_IF = 1'b0, GRANT_MEM = 1'b1} grant_e;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational two-way round-robin chooser between IF and MEM.
// Ports: if_req, mem_req   - pending requests
//        last_grant        - owner of the previous grant (GRANT_IF / GRANT_MEM)
//        grant_valid       - at least one request is pending
//        grant_owner       - chosen requester; contested grants go opposite to last_grant
module arb_rr_pick
    import cpu_bus_pkg::*;
(
    input  logic if_req,
    input  logic mem_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_owner
);
    always_comb begin
        grant_valid = if_req | mem_req;
        grant_owner = (if_req && mem_req) ? ((last_grant == GRANT_IF) ? GRANT_MEM : GRANT_IF)
                                          : (mem_req ? GRANT_MEM : GRANT_IF);
    end
endmodule

// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: shares the single MIO bus between the IF (fetch) and MEM (load/store) stages.
// Ports: clk, rst (async, active-high)
//        if_req/if_addr -> if_rdata/if_ready/if_stall            fetch requester
//        mem_req/mem_we/mem_addr/mem_wdata -> mem_rdata/mem_ready/mem_stall  load/store requester
//        bus_addr/bus_wdata/bus_we/bus_cpu_mio -> bus, bus_rdata/bus_ready <- bus
//        bus_err  sticky abort flag
// Macro ARB_TIMEOUT_EN builds the bus_ready timeout counter; without it BUSY waits forever.
module mio_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int               TIMEOUT_CYCLES = 255,
    parameter int               TIMEOUT_W      = 8,
    parameter logic [BUS_W-1:0] ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [BUS_W-1:0] if_addr,
    output logic [BUS_W-1:0] if_rdata,
    output logic             if_ready,
    output logic             if_stall,
    input  logic             mem_req,
    input  logic             mem_we,
    input  logic [BUS_W-1:0] mem_addr,
    input  logic [BUS_W-1:0] mem_wdata,
    output logic [BUS_W-1:0] mem_rdata,
    output logic             mem_ready,
    output logic             mem_stall,
    output logic [BUS_W-1:0] bus_addr,
    output logic [BUS_W-1:0] bus_wdata,
    output logic             bus_we,
    output logic             bus_cpu_mio,
    input  logic [BUS_W-1:0] bus_rdata,
    input  logic             bus_ready,
    output logic             bus_err
);
    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [BUS_W-1:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [BUS_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
    logic             bus_we_q, bus_we_d, bus_cpu_mio_q, bus_cpu_mio_d;
    logic             if_ready_q, if_ready_d, mem_ready_q, mem_ready_d;
    logic             bus_err_q, bus_err_d;
    logic             grant_valid, grant_owner, abort, done;

    arb_rr_pick u_pick (
        .if_req      (if_req),
        .mem_req     (mem_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    // The limit is reached on the edge that would bump the count to TIMEOUT_CYCLES;
    // a bus_ready on that same cycle still completes normally.
    assign abort = (state_q != IDLE) && !bus_ready && (tmo_q == TMO_LAST);
    always_comb tmo_d = (state_q == IDLE) ? '0 : tmo_q + 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    // Keeps the timeout parameters referenced when the counter is not built.
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = TIMEOUT_CYCLES[0] ^ TIMEOUT_W[0];
    assign abort = 1'b0;
`endif

    assign done = (state_q != IDLE) && (bus_ready || abort);

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_we_d      = bus_we_q;
        bus_cpu_mio_d = bus_cpu_mio_q;
        if_rdata_d    = if_rdata_q;
        mem_rdata_d   = mem_rdata_q;
        if_ready_d    = 1'b0;
        mem_ready_d   = 1'b0;
        bus_err_d     = bus_err_q | abort;
        if (state_q == IDLE) begin
            if (grant_valid) begin
                state_d       = (grant_owner == GRANT_MEM) ? MEM_BUSY : IF_BUSY;
                last_grant_d  = grant_owner;
                bus_addr_d    = (grant_owner == GRANT_MEM) ? mem_addr : if_addr;
                bus_wdata_d   = (grant_owner == GRANT_MEM) ? mem_wdata : '0;
                bus_we_d      = (grant_owner == GRANT_MEM) && mem_we;
                bus_cpu_mio_d = 1'b1;
            end
        end else if (done) begin
            state_d       = IDLE;
            bus_cpu_mio_d = 1'b0;
            bus_we_d      = 1'b0;
            if (state_q == MEM_BUSY) begin
                mem_rdata_d = bus_ready ? bus_rdata : ERR_RDATA;
                mem_ready_d = 1'b1;
            end else begin
                if_rdata_d  = bus_ready ? bus_rdata : ERR_RDATA;
                if_ready_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_IF;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_we_q      <= 1'b0;
            bus_cpu_mio_q <= 1'b0;
            if_rdata_q    <= '0;
            mem_rdata_q   <= '0;
            if_ready_q    <= 1'b0;
            mem_ready_q   <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_we_q      <= bus_we_d;
            bus_cpu_mio_q <= bus_cpu_mio_d;
            if_rdata_q    <= if_rdata_d;
            mem_rdata_q   <= mem_rdata_d;
            if_ready_q    <= if_ready_d;
            mem_ready_q   <= mem_ready_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign if_rdata    = if_rdata_q;
    assign if_ready    = if_ready_q;
    assign if_stall    = if_req & ~if_ready_q;
    assign mem_rdata   = mem_rdata_q;
    assign mem_ready   = mem_ready_q;
    assign mem_stall   = mem_req & ~mem_ready_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_we      = bus_we_q;
    assign bus_cpu_mio = bus_cpu_mio_q;
    assign bus_err     = bus_err_q;
endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Shares the CPU's single memory-mapped bus (one address/data/write-enable set, MIO_ready handshake) between two requesters.
- Requester 1 is the IF stage (instruction fetch). Requester 2 is the MEM stage (load/store).
- Sequences each bus transaction and returns read data and a one-cycle ready pulse to the requester that owns it.
- Produces the per-stage stall signals the pipeline's hazard logic consumes while a requester waits for the bus.

Parameters:
- TIMEOUT_CYCLES, 255: maximum wait cycles for bus_ready before abort (used only with ARB_TIMEOUT_EN).
- TIMEOUT_W, 8: width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on an aborted transaction.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  IF requests an instruction read; held until if_ready.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched word, valid when if_ready.
- if_ready  out  1  one-cycle completion pulse for IF.
- if_stall  out  1  combinational: if_req & ~if_ready.
- mem_req  in  1  MEM requests a load or store; held until mem_ready.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data, valid when mem_ready.
- mem_ready  out  1  one-cycle completion pulse for MEM.
- mem_stall  out  1  combinational: mem_req & ~mem_ready.
- bus_addr  out  32  registered bus address (Addr_out).
- bus_wdata  out  32  registered bus write data (Data_out).
- bus_we  out  1  registered bus write strobe (mem_w).
- bus_cpu_mio  out  1  high while a transaction owns the bus (CPU_MIO).
- bus_rdata  in  32  bus read data (Data_in).
- bus_ready  in  1  bus completion (MIO_ready).
- bus_err  out  1  sticky abort flag; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - All bus_* outputs = 0.
  - if_rdata = mem_rdata = 0; if_ready = mem_ready = 0; bus_err = 0.
  - last_grant = IF, so MEM wins the first contested grant.
- States: IDLE, IF_BUSY, MEM_BUSY.
- IDLE:
  - Only mem_req set -> MEM_BUSY.
  - Only if_req set -> IF_BUSY.
  - Both set -> grant the requester opposite to last_grant (round-robin), then update last_grant.
  - On grant, register addr/wdata/we; bus_cpu_mio = 1 from the next cycle.
  - IF grants always drive bus_we = 0 and bus_wdata = 0.
- *_BUSY:
  - Bus outputs are held stable.
  - On a cycle with bus_ready = 1: capture bus_rdata into the owner's rdata register, pulse the owner's ready for exactly one cycle (next cycle), clear bus_cpu_mio and bus_we, return to IDLE.
  - Stores also capture bus_rdata; MEM ignores it.
- Latency:
  - Minimum 2 cycles from req sampled in IDLE to ready: grant edge, bus_ready in the first BUSY cycle, then the ready pulse.
  - A new grant is possible in the cycle the ready pulse is high, i.e. the arbiter IDLEs one cycle between transactions.
- The ready pulse lasts one cycle; the requester must drop or change req in the pulse cycle. A req still high after the pulse is treated as a new request.
- Requester drops req while its transaction is BUSY: the transaction still completes on the bus and ready still pulses; no abort.
- Address/data changes during BUSY are ignored; values latched at grant are used.
- bus_ready high while IDLE is ignored.
- Reset mid-transaction: bus released immediately and no ready pulse is issued; the pipeline is reset alongside.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W counter clears at grant and increments each BUSY cycle without bus_ready.
  - When it reaches TIMEOUT_CYCLES, the transaction aborts: the owner's rdata = ERR_RDATA, its ready pulses, bus_err sets (sticky until rst), state returns to IDLE.
  - bus_ready in the same cycle as the limit takes precedence: normal completion, no error.
- Not defined: no counter is built; BUSY waits indefinitely and bus_err is tied 0.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - the arbiter state enum (IDLE/IF_BUSY/MEM_BUSY);
  - grant-owner encoding (GRANT_IF = 0, GRANT_MEM = 1);
  - the ERR_RDATA default;
  - the bus width constant 32.
- One sub-module is natural: arb_rr_pick, the combinational two-way round-robin chooser (inputs if_req, mem_req, last_grant; outputs grant_valid, grant_owner). The FSM, datapath latches and timeout counter stay in the top module.

Test Plan:
- Reset, then IF-only fetch: if_req = 1, if_addr = 0x0000_0040; bus_ready pulsed in the first BUSY cycle with bus_rdata = 0x2008_0005 -> bus_addr = 0x40, bus_we = 0, if_ready pulses one cycle 2 cycles after the request, if_rdata = 0x2008_0005, if_stall high until then.
- Store: mem_req = 1, mem_we = 1, mem_addr = 0x0000_1000, mem_wdata = 0xCAFE_0001; bus_ready delayed 3 cycles -> bus_we = 1 and bus_wdata = 0xCAFE_0001 held stable all 3 wait cycles; mem_ready pulses once; bus_we = 0 afterwards.
- Contention: if_req and mem_req held continuously, bus_ready always 1 -> grant order MEM, IF, MEM, IF; no requester gets two consecutive grants while both are pending.
- Requester drops mem_req mid-BUSY -> transaction finishes on bus_ready, mem_ready still pulses; if_req pending is granted next.
- Async rst asserted mid-BUSY, between clock edges -> bus_cpu_mio, bus_we and the ready outputs go 0 without waiting for a clock edge; after release, the first request is serviced normally.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 4, bus_ready held 0 -> ready pulses after the 4th wait cycle, rdata = 0xDEAD_BEEF, bus_err = 1 and stays 1 through later good transactions.
